// File: rtl/dev_port_fifo.sv
// Per-device port buffer: TX FIFO from the agent toward the bus, and an
// address-filtered RX FIFO from the bus toward the agent. Both FIFOs are FWFT.
module dev_port_fifo #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [pckg_sz-1:0]           wr_data,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         rd,
  output logic                         rx_valid,
  output logic [pckg_sz-1:0]           rd_data,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic                         tx_ovf,
  output logic                         rx_ovf,
  output logic                         tx_unf
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth+1);

  logic [pckg_sz-1:0] r_tx_mem [depth];
  logic [AW-1:0]      r_tx_wp;
  logic [AW-1:0]      r_tx_rp;
  logic [CW-1:0]      r_tx_cnt;
  logic               r_tx_ovf;
  logic               r_tx_unf;

  logic [pckg_sz-1:0] r_rx_mem [depth];
  logic [AW-1:0]      r_rx_wp;
  logic [AW-1:0]      r_rx_rp;
  logic [CW-1:0]      r_rx_cnt;
  logic               r_rx_ovf;

  logic w_tx_empty, w_tx_full, w_tx_pop_ok, w_tx_wr_ok;
  logic w_rx_empty, w_rx_full, w_rx_rd_ok, w_rx_wr_ok, w_rx_match;

  always_comb begin
    w_tx_empty  = (r_tx_cnt == '0);
    w_tx_full   = (r_tx_cnt == CW'(depth));
    w_tx_pop_ok = pop && !w_tx_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    w_tx_wr_ok  = wr && (!w_tx_full || w_tx_pop_ok);

    w_rx_empty  = (r_rx_cnt == '0);
    w_rx_full   = (r_rx_cnt == CW'(depth));
    w_rx_match  = push && ((D_push[pckg_sz-1 -: 8] == id) ||
                           (D_push[pckg_sz-1 -: 8] == broadcast));
    w_rx_rd_ok  = rd && !w_rx_empty;
    w_rx_wr_ok  = w_rx_match && (!w_rx_full || w_rx_rd_ok);
  end

  // Storage needs no reset: emptiness is tracked by the counters and masks the outputs.
  always_ff @(posedge clk) begin
    if (w_tx_wr_ok) r_tx_mem[r_tx_wp] <= wr_data;
    if (w_rx_wr_ok) r_rx_mem[r_rx_wp] <= D_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
      r_tx_unf <= 1'b0;
    end else begin
      if (w_tx_wr_ok)          r_tx_wp  <= r_tx_wp + AW'(1);
      if (w_tx_pop_ok)         r_tx_rp  <= r_tx_rp + AW'(1);
      if (wr && !w_tx_wr_ok)   r_tx_ovf <= 1'b1;
      if (pop && w_tx_empty)   r_tx_unf <= 1'b1;
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_wr_ok) - CW'(w_tx_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_rx_wr_ok)                r_rx_wp  <= r_rx_wp + AW'(1);
      if (w_rx_rd_ok)                r_rx_rp  <= r_rx_rp + AW'(1);
      if (w_rx_match && !w_rx_wr_ok) r_rx_ovf <= 1'b1;
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_wr_ok) - CW'(w_rx_rd_ok);
    end
  end

  always_comb begin
    pndng    = !w_tx_empty;
    D_pop    = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
    rx_valid = !w_rx_empty;
    rd_data  = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
    tx_count = r_tx_cnt;
    rx_count = r_rx_cnt;
    tx_ovf   = r_tx_ovf;
    rx_ovf   = r_rx_ovf;
    tx_unf   = r_tx_unf;
  end

endmodule

// File: tb/tb_dev_port_fifo.sv
// Randomised and directed bench for dev_port_fifo; a queue-based reference model
// holds expected contents and a negedge monitor compares every visible output.
module tb_dev_port_fifo;

  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  ID    = 8'h02;
  localparam logic [7:0]  BCAST = 8'hFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0, pop = 1'b0, push = 1'b0, rd = 1'b0;
  logic [15:0] wr_data = '0, D_push = '0;
  logic        pndng, rx_valid, tx_ovf, rx_ovf, tx_unf;
  logic [15:0] D_pop, rd_data;
  logic [3:0]  tx_count, rx_count;

  dev_port_fifo #(.pckg_sz(16), .depth(DEPTH), .id(ID), .broadcast(BCAST)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data), .pndng(pndng),
    .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push), .rd(rd),
    .rx_valid(rx_valid), .rd_data(rd_data), .tx_count(tx_count),
    .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .tx_unf(tx_unf)
  );

  always #5 clk = ~clk;

  // Reference model: expected FIFO contents as queues plus sticky flags.
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  logic        m_tx_ovf = 1'b0, m_rx_ovf = 1'b0, m_tx_unf = 1'b0;
  bit          mon_on = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rs, input logic w, input logic [15:0] wd,
                            input logic p, input logic ps, input logic [15:0] dp,
                            input logic r);
    bit tx_pop_ok, rx_rd_ok, match;
    if (rs) begin
      m_tx.delete();
      m_rx.delete();
      m_tx_ovf = 1'b0;
      m_rx_ovf = 1'b0;
      m_tx_unf = 1'b0;
      return;
    end
    tx_pop_ok = p && (m_tx.size() > 0);
    if (p && m_tx.size() == 0) m_tx_unf = 1'b1;
    if (w) begin
      if (m_tx.size() < DEPTH || tx_pop_ok) m_tx.push_back(wd);
      else m_tx_ovf = 1'b1;
    end
    if (tx_pop_ok) void'(m_tx.pop_front());

    match    = ps && (dp[15:8] == ID || dp[15:8] == BCAST);
    rx_rd_ok = r && (m_rx.size() > 0);
    if (match) begin
      if (m_rx.size() < DEPTH || rx_rd_ok) m_rx.push_back(dp);
      else m_rx_ovf = 1'b1;
    end
    if (rx_rd_ok) void'(m_rx.pop_front());
  endtask

  task automatic step(input logic rs, input logic w, input logic [15:0] wd,
                      input logic p, input logic ps, input logic [15:0] dp,
                      input logic r);
    reset = rs; wr = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd = r;
    @(posedge clk);
    model_edge(rs, w, wd, p, ps, dp, r);
    #1;
    reset = 1'b0; wr = 1'b0; pop = 1'b0; push = 1'b0; rd = 1'b0;
  endtask

  // Monitor: compares every visible output against the model's expected state.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("pndng",    {31'b0, pndng},    {31'b0, m_tx.size() > 0});
      chk("D_pop",    {16'b0, D_pop},    {16'b0, (m_tx.size() > 0) ? m_tx[0] : 16'h0});
      chk("tx_count", {28'b0, tx_count}, m_tx.size());
      chk("rx_valid", {31'b0, rx_valid}, {31'b0, m_rx.size() > 0});
      chk("rd_data",  {16'b0, rd_data},  {16'b0, (m_rx.size() > 0) ? m_rx[0] : 16'h0});
      chk("rx_count", {28'b0, rx_count}, m_rx.size());
      chk("tx_ovf",   {31'b0, tx_ovf},   {31'b0, m_tx_ovf});
      chk("rx_ovf",   {31'b0, rx_ovf},   {31'b0, m_rx_ovf});
      chk("tx_unf",   {31'b0, tx_unf},   {31'b0, m_tx_unf});
    end
  end

  initial begin
    logic [15:0] d;
    logic [7:0]  a;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    mon_on = 1'b1;
    chk("rst_pndng", {31'b0, pndng}, 0);
    chk("rst_D_pop", {16'b0, D_pop}, 0);

    // Basic write/pop
    step(0, 1, 16'hA1B2, 0, 0, 0, 0);
    chk("first_pndng", {31'b0, pndng}, 1);
    chk("first_head",  {16'b0, D_pop}, 32'hA1B2);
    step(0, 1, 16'h03C4, 0, 0, 0, 0);
    chk("two_count", {28'b0, tx_count}, 2);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("second_head", {16'b0, D_pop}, 32'h03C4);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("drained_head", {16'b0, D_pop}, 0);
    chk("no_flags", {29'b0, tx_ovf, rx_ovf, tx_unf}, 0);

    // Fill, overflow, full wr+pop, drain with wrap
    for (int i = 0; i < 8; i++) step(0, 1, 16'(i), 0, 0, 0, 0);
    step(0, 1, 16'h0099, 0, 0, 0, 0);
    chk("tx_full_count", {28'b0, tx_count}, 8);
    chk("tx_ovf_set", {31'b0, tx_ovf}, 1);
    step(0, 1, 16'h00AB, 1, 0, 0, 0);
    chk("full_wrpop_count", {28'b0, tx_count}, 8);
    chk("full_wrpop_head", {16'b0, D_pop}, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, 0);

    // Underflow, and wr+pop on empty
    step(0, 0, 0, 1, 0, 0, 0);
    chk("tx_unf_set", {31'b0, tx_unf}, 1);
    step(0, 1, 16'h1234, 1, 0, 0, 0);
    chk("empty_wrpop_count", {28'b0, tx_count}, 1);
    chk("empty_wrpop_head", {16'b0, D_pop}, 32'h1234);
    step(0, 0, 0, 1, 0, 0, 0);

    // RX address filter
    step(0, 0, 0, 0, 1, 16'h02AA, 0);
    step(0, 0, 0, 0, 1, 16'h0155, 0);
    step(0, 0, 0, 0, 1, 16'hFF77, 0);
    chk("rx_filter_count", {28'b0, rx_count}, 2);
    chk("rx_filter_head", {16'b0, rd_data}, 32'h02AA);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rx_filter_second", {16'b0, rd_data}, 32'hFF77);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // RX fill, overflow, push+rd on full
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 16'h0200 + 16'(i), 0);
    step(0, 0, 0, 0, 1, 16'h02EE, 0);
    chk("rx_ovf_set", {31'b0, rx_ovf}, 1);
    step(0, 0, 0, 0, 1, 16'hFFDD, 1);
    chk("rx_full_pushrd_count", {28'b0, rx_count}, 8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

    // Reset with both FIFOs half full and flags set
    for (int i = 0; i < 4; i++) step(0, 1, 16'h5500 + 16'(i), 0, 0, 0, 0);
    step(1, 1, 16'h7777, 1, 1, 16'h0201, 1);
    chk("rst_mid_counts", {24'b0, tx_count, rx_count}, 0);
    chk("rst_mid_flags", {29'b0, tx_ovf, rx_ovf, tx_unf}, 0);
    step(0, 1, 16'hBEEF, 0, 0, 0, 0);
    chk("post_rst_head", {16'b0, D_pop}, 32'hBEEF);
    step(0, 0, 0, 1, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 2))
        0: a = ID;
        1: a = BCAST;
        default: a = 8'($urandom);
      endcase
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < 55, 16'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 60, {a, d[7:0]},
           $urandom_range(0, 99) < 45);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
